// File: rtl/slot_allocator_pkg.sv
// Shared types for the surge protector reassembly slot allocator.
// Default slot-count exponent and slot index/count widths.
package slot_allocator_pkg;

   localparam int SLOT_LOG_DEFAULT = 4;
   localparam int SLOTS_DEFAULT    = 1 << SLOT_LOG_DEFAULT;

   typedef logic [SLOT_LOG_DEFAULT-1:0] slot_idx_t;
   typedef logic [SLOT_LOG_DEFAULT:0]   slot_cnt_t;

endpackage

// File: rtl/slot_allocator_ffs.sv
// Combinational find-first-set encoder.
// lsb_o is the lowest set bit index; zero_o flags an all-zero vector.
module slot_allocator_ffs #(
   parameter int WIDTH_LOG = 4
) (
   input  logic [(1<<WIDTH_LOG)-1:0] vec_i,
   output logic [WIDTH_LOG-1:0]      lsb_o,
   output logic                      zero_o
);

   localparam int W = 1 << WIDTH_LOG;

   always_comb begin
      lsb_o = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec_i[i]) lsb_o = WIDTH_LOG'(i);
      end
   end

   assign zero_o = ~|vec_i;

endmodule

// File: rtl/slot_allocator.sv
// Bitmap free-list handing out the lowest free slot over valid/ready.
// Optional double-free detection: define SLOT_ALLOC_CHECK_EN.
module slot_allocator
   import slot_allocator_pkg::*;
#(
   parameter int SLOT_LOG = SLOT_LOG_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                alloc_valid,
   input  logic                alloc_ready,
   output logic [SLOT_LOG-1:0] alloc_idx,
   input  logic                free_valid,
   input  logic [SLOT_LOG-1:0] free_idx,
   output logic [SLOT_LOG:0]   occupancy,
   output logic                full,
   output logic                empty,
   output logic                err_double_free
);

   localparam int SLOTS = 1 << SLOT_LOG;

   logic [SLOTS-1:0]    map_q, map_d;
   logic                rsv_vld_q, rsv_vld_d;
   logic [SLOT_LOG-1:0] rsv_idx_q, rsv_idx_d;
   logic [SLOT_LOG:0]   occ_q, occ_d;

   logic [SLOT_LOG-1:0] ffs_lsb;
   logic                ffs_zero;
   logic                hs;
   logic                load;
   logic                bad_free;
   logic                free_acc;

   slot_allocator_ffs #(
      .WIDTH_LOG (SLOT_LOG)
   ) u_ffs (
      .vec_i  (map_q),
      .lsb_o  (ffs_lsb),
      .zero_o (ffs_zero)
   );

   assign hs   = rsv_vld_q & alloc_ready;
   assign load = (~rsv_vld_q | hs) & ~ffs_zero;

`ifdef SLOT_ALLOC_CHECK_EN
   logic err_q;

   // A release of a slot already free, or of the one sitting in the
   // reservation register, would create a duplicate owner.
   assign bad_free = free_valid &
                     (map_q[free_idx] |
                      (rsv_vld_q & (free_idx == rsv_idx_q)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_q | bad_free;
   end

   assign err_double_free = err_q;
`else
   assign bad_free        = 1'b0;
   assign err_double_free = 1'b0;
`endif

   assign free_acc = free_valid & ~bad_free;

   always_comb begin
      map_d = map_q;
      if (load)     map_d[ffs_lsb]  = 1'b0;
      if (free_acc) map_d[free_idx] = 1'b1;
   end

   always_comb begin
      rsv_vld_d = rsv_vld_q;
      rsv_idx_d = rsv_idx_q;
      if (load) begin
         rsv_vld_d = 1'b1;
         rsv_idx_d = ffs_lsb;
      end else if (hs) begin
         rsv_vld_d = 1'b0;
      end
   end

   always_comb begin
      occ_d = occ_q;
      unique case ({hs, free_acc})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = (occ_q != '0) ? occ_q - 1'b1 : occ_q;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         map_q     <= '1;
         rsv_vld_q <= 1'b0;
         rsv_idx_q <= '0;
         occ_q     <= '0;
      end else begin
         map_q     <= map_d;
         rsv_vld_q <= rsv_vld_d;
         rsv_idx_q <= rsv_idx_d;
         occ_q     <= occ_d;
      end
   end

   assign alloc_valid = rsv_vld_q;
   assign alloc_idx   = rsv_idx_q;
   assign occupancy   = occ_q;
   assign full        = (occ_q == (SLOT_LOG+1)'(SLOTS));
   assign empty       = (occ_q == '0);

endmodule

// File: tb/tb_slot_allocator.sv
// Directed + random bench for slot_allocator against a slot-pool model.
// Build with SLOT_ALLOC_CHECK_EN to also exercise double-free handling.
module tb_slot_allocator;
   import slot_allocator_pkg::*;

   localparam int N = SLOTS_DEFAULT;

   logic      clk = 1'b0;
   logic      rst_n = 1'b0;
   logic      alloc_valid;
   logic      alloc_ready = 1'b0;
   slot_idx_t alloc_idx;
   logic      free_valid = 1'b0;
   slot_idx_t free_idx = '0;
   slot_cnt_t occupancy;
   logic      full;
   logic      empty;
   logic      err_double_free;

   int total = 0;
   int bad = 0;

   // model: pool of free slots, the presented slot, slots held by consumers
   bit m_free[N];
   bit m_vld;
   int m_idx;
   int m_occ;
   bit m_err;
   int taken[$];

   slot_allocator dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .alloc_valid     (alloc_valid),
      .alloc_ready     (alloc_ready),
      .alloc_idx       (alloc_idx),
      .free_valid      (free_valid),
      .free_idx        (free_idx),
      .occupancy       (occupancy),
      .full            (full),
      .empty           (empty),
      .err_double_free (err_double_free)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < N; i++) m_free[i] = 1'b1;
      m_vld = 1'b0;
      m_idx = 0;
      m_occ = 0;
      m_err = 1'b0;
      taken.delete();
   endfunction

   function automatic void m_step(input bit rdy, input bit fv, input int fi);
      bit hs;
      bit acc;
      int pick;
      hs  = m_vld && rdy;
      acc = fv;
`ifdef SLOT_ALLOC_CHECK_EN
      if (fv && (m_free[fi] || (m_vld && fi == m_idx))) begin
         acc   = 1'b0;
         m_err = 1'b1;
      end
`endif
      if (hs) taken.push_back(m_idx);
      if (!m_vld || hs) begin
         pick = -1;
         for (int i = N - 1; i >= 0; i--) if (m_free[i]) pick = i;
         if (pick >= 0) begin
            m_idx = pick;
            m_vld = 1'b1;
            m_free[pick] = 1'b0;
         end else begin
            m_vld = 1'b0;
         end
      end
      if (acc) begin
         m_free[fi] = 1'b1;
         for (int k = 0; k < taken.size(); k++) begin
            if (taken[k] == fi) begin
               taken.delete(k);
               break;
            end
         end
      end
      m_occ = m_occ + int'(hs) - int'(acc);
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, alloc_valid, m_vld);
      chk({tag, ".idx"}, alloc_idx, m_idx);
      chk({tag, ".occ"}, occupancy, m_occ);
      chk({tag, ".full"}, full, m_occ == N);
      chk({tag, ".empty"}, empty, m_occ == 0);
      chk({tag, ".err"}, err_double_free, m_err);
   endtask

   task automatic cyc(input bit r, input bit fv, input int fi,
                      input string tag);
      alloc_ready = r;
      free_valid  = fv;
      free_idx    = slot_idx_t'(fi);
      @(posedge clk);
      m_step(r, fv, fi);
      #1;
      check_all(tag);
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      alloc_ready = 1'b0;
      free_valid  = 1'b0;
      rst_n       = 1'b0;
      #1;
      m_reset();
      check_all(tag);
      chk({tag, ".valid0"}, alloc_valid, 0);
      chk({tag, ".empty1"}, empty, 1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bit r;
      bit fv;
      int fi;
      int k;

      do_reset("rst0");

      cyc(0, 0, 0, "first");
      for (int i = 0; i < N; i++) begin
         cyc(1, 0, 0, "drain");
         if (i < N - 1) chk("drain.seq", alloc_idx, i + 1);
      end
      chk("full16", full, 1);
      chk("gone", alloc_valid, 0);

      cyc(0, 1, 9, "free9");
      chk("free9.occ", occupancy, 15);
      chk("free9.nv", alloc_valid, 0);
      cyc(0, 0, 0, "wait9");
      chk("idx9", alloc_idx, 9);
      cyc(1, 0, 0, "take9");
      chk("occ16", occupancy, 16);

      cyc(0, 1, 7, "free7");
      cyc(0, 0, 0, "hold7");
      cyc(0, 1, 5, "free5");
      cyc(0, 1, 3, "free3");
      chk("held7", alloc_idx, 7);
      cyc(1, 0, 0, "take7");
      chk("idx3", alloc_idx, 3);
      cyc(1, 0, 0, "take3");
      chk("idx5", alloc_idx, 5);

      do_reset("rst1");
      cyc(0, 0, 0, "s.first");
      for (int i = 0; i < 7; i++) cyc(1, 0, 0, "s.fill");
      chk("s.occ7pre", occupancy, 7);
      cyc(1, 1, 2, "s.both");
      chk("s.occ7", occupancy, 7);
      chk("s.idx8", alloc_idx, 8);
      cyc(1, 0, 0, "s.next");
      chk("s.idx2", alloc_idx, 2);

`ifdef SLOT_ALLOC_CHECK_EN
      do_reset("rst2");
      cyc(0, 1, 12, "c.dbl");
      chk("c.err", err_double_free, 1);
      chk("c.occ0", occupancy, 0);
      cyc(0, 1, 0, "c.held");
      chk("c.occ0b", occupancy, 0);
      chk("c.sticky", err_double_free, 1);
      cyc(1, 0, 0, "c.take");
      chk("c.idx1", alloc_idx, 1);
`endif

      do_reset("rst3");
      cyc(0, 0, 0, "m.first");
      for (int i = 0; i < 10; i++) cyc(1, 0, 0, "m.fill");
      chk("m.occ10", occupancy, 10);
      do_reset("m.rst");
      cyc(0, 0, 0, "m.restart");
      chk("m.idx0", alloc_idx, 0);
      chk("m.vld", alloc_valid, 1);

      for (int n = 0; n < 400; n++) begin
         r  = ($urandom_range(0, 3) != 0);
         fv = 1'b0;
         fi = 0;
         if (taken.size() > 0 && $urandom_range(0, 2) == 0) begin
            k  = $urandom_range(0, taken.size() - 1);
            fi = taken[k];
            fv = 1'b1;
         end
         cyc(r, fv, fi, "rnd");
         if (n == 200) do_reset("rnd.rst");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
